leaf_net_interface: RTL and testbench

LEAF_NET_INTERFACE -- requirements
Module: leaf_net_interface

---
 rtl/leaf_net_interface.sv | 150 +++++++++++++++
 tb/tb_leaf_net_interface.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_net_interface.sv
// Leaf network interface: buffers PE packets toward the router parent port and
// filters router packets by destination address into a receive buffer for the PE.

module leaf_net_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  // A push is refused when full even if a pop frees a slot in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
    else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
endmodule

module leaf_net_interface #(
  parameter int         WIDTH   = 32,
  parameter logic [2:0] ADDRESS = 3'd0,
  parameter int         DEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pe_tx_valid,
  output logic             pe_tx_ready,
  input  logic [2:0]       pe_tx_dest,
  input  logic [1:0]       pe_tx_type,
  input  logic [23:0]      pe_tx_data,
  output logic             net_out_valid,
  input  logic             net_out_ready,
  output logic [WIDTH-1:0] net_out_data,
  input  logic             net_in_valid,
  output logic             net_in_ready,
  input  logic [WIDTH-1:0] net_in_data,
  output logic             pe_rx_valid,
  input  logic             pe_rx_ready,
  output logic [2:0]       pe_rx_src,
  output logic [1:0]       pe_rx_type,
  output logic [23:0]      pe_rx_data,
  output logic [7:0]       drop_count
);
  // The RX buffer never needs the destination field, so it holds src/type/payload only.
  localparam int RXW = WIDTH - 3;

  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [WIDTH-1:0] tx_head;
  logic [RXW-1:0]   rx_head;
  logic             tx_push, tx_pop, rx_push, rx_pop;
  logic             net_accept, addr_hit, drop_event;
  logic [7:0]       drop_count_q, drop_count_d;

  // Handshake outputs are forced low while reset is held so nothing transfers that cycle.
  assign pe_tx_ready   = !reset && !tx_full;
  assign net_out_valid = !reset && !tx_empty;
  assign net_in_ready  = !reset && !rx_full;
  assign pe_rx_valid   = !reset && !rx_empty;

  assign tx_push    = pe_tx_valid && pe_tx_ready;
  assign tx_pop     = net_out_valid && net_out_ready;
  assign net_accept = net_in_valid && net_in_ready;
  assign addr_hit   = (net_in_data[WIDTH-1:WIDTH-3] == ADDRESS);
  assign rx_push    = net_accept && addr_hit;
  assign drop_event = net_accept && !addr_hit;
  assign rx_pop     = pe_rx_valid && pe_rx_ready;

  leaf_net_fifo #(.W(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .wdata_i ({pe_tx_dest, ADDRESS, pe_tx_type, pe_tx_data}),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  leaf_net_fifo #(.W(RXW), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .wdata_i (net_in_data[RXW-1:0]),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  // Data outputs are zeroed when idle so unwritten buffer slots never leak X.
  assign net_out_data = net_out_valid ? tx_head : '0;
  assign pe_rx_src    = pe_rx_valid ? rx_head[28:26] : '0;
  assign pe_rx_type   = pe_rx_valid ? rx_head[25:24] : '0;
  assign pe_rx_data   = pe_rx_valid ? rx_head[23:0]  : '0;

  always_comb begin
    drop_count_d = drop_count_q;
    if (drop_event && drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) drop_count_q <= '0;
    else       drop_count_q <= drop_count_d;
  end

  assign drop_count = reset ? 8'd0 : drop_count_q;
endmodule

// File: tb/tb_leaf_net_interface.sv
// Directed bench for leaf_net_interface (ADDRESS=2, DEPTH=4) with a queue-based
// reference model checked every cycle plus literal expectations for key scenarios.

module tb_leaf_net_interface;
  localparam logic [2:0] ADDR  = 3'd2;
  localparam int         DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pe_tx_valid = 1'b0;
  logic        pe_tx_ready;
  logic [2:0]  pe_tx_dest = '0;
  logic [1:0]  pe_tx_type = '0;
  logic [23:0] pe_tx_data = '0;
  logic        net_out_valid;
  logic        net_out_ready = 1'b0;
  logic [31:0] net_out_data;
  logic        net_in_valid = 1'b0;
  logic        net_in_ready;
  logic [31:0] net_in_data = '0;
  logic        pe_rx_valid;
  logic        pe_rx_ready = 1'b0;
  logic [2:0]  pe_rx_src;
  logic [1:0]  pe_rx_type;
  logic [23:0] pe_rx_data;
  logic [7:0]  drop_count;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] tx_q [$];
  logic [28:0] rx_q [$];
  int          drop_m = 0;
  logic [2:0]  srcs [4] = '{3'd1, 3'd2, 3'd3, 3'd6};

  always #5 clk = ~clk;

  leaf_net_interface #(.WIDTH(32), .ADDRESS(ADDR), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .pe_tx_valid   (pe_tx_valid),
    .pe_tx_ready   (pe_tx_ready),
    .pe_tx_dest    (pe_tx_dest),
    .pe_tx_type    (pe_tx_type),
    .pe_tx_data    (pe_tx_data),
    .net_out_valid (net_out_valid),
    .net_out_ready (net_out_ready),
    .net_out_data  (net_out_data),
    .net_in_valid  (net_in_valid),
    .net_in_ready  (net_in_ready),
    .net_in_data   (net_in_data),
    .pe_rx_valid   (pe_rx_valid),
    .pe_rx_ready   (pe_rx_ready),
    .pe_rx_src     (pe_rx_src),
    .pe_rx_type    (pe_rx_type),
    .pe_rx_data    (pe_rx_data),
    .drop_count    (drop_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: two bounded queues and a saturating drop counter.
  always @(posedge clk) begin : model
    automatic bit tx_acc = pe_tx_valid && (tx_q.size() < DEPTH);
    automatic bit tx_pop = net_out_ready && (tx_q.size() > 0);
    automatic bit in_acc = net_in_valid && (rx_q.size() < DEPTH);
    automatic bit rx_pop = pe_rx_ready && (rx_q.size() > 0);
    if (reset) begin
      tx_q.delete();
      rx_q.delete();
      drop_m = 0;
    end else begin
      if (tx_pop) void'(tx_q.pop_front());
      if (tx_acc) tx_q.push_back({pe_tx_dest, ADDR, pe_tx_type, pe_tx_data});
      if (rx_pop) void'(rx_q.pop_front());
      if (in_acc) begin
        if (net_in_data[31:29] == ADDR) rx_q.push_back(net_in_data[28:0]);
        else if (drop_m < 255) drop_m++;
      end
    end
  end

  always @(negedge clk) begin : compare
    check("pe_tx_ready", {31'd0, pe_tx_ready}, {31'd0, (!reset && tx_q.size() < DEPTH)});
    check("net_out_valid", {31'd0, net_out_valid}, {31'd0, (!reset && tx_q.size() > 0)});
    check("net_in_ready", {31'd0, net_in_ready}, {31'd0, (!reset && rx_q.size() < DEPTH)});
    check("pe_rx_valid", {31'd0, pe_rx_valid}, {31'd0, (!reset && rx_q.size() > 0)});
    check("drop_count", {24'd0, drop_count}, reset ? 32'd0 : 32'(drop_m));
    check("net_out_data_known", {31'd0, $isunknown(net_out_data)}, 32'd0);
    check("pe_rx_data_known", {31'd0, $isunknown({pe_rx_src, pe_rx_type, pe_rx_data})}, 32'd0);
    if (!reset && tx_q.size() > 0) check("net_out_data", net_out_data, tx_q[0]);
    if (!reset && rx_q.size() > 0) begin
      check("pe_rx_src", {29'd0, pe_rx_src}, {29'd0, rx_q[0][28:26]});
      check("pe_rx_type", {30'd0, pe_rx_type}, {30'd0, rx_q[0][25:24]});
      check("pe_rx_data", {8'd0, pe_rx_data}, {8'd0, rx_q[0][23:0]});
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    repeat (3) step();
    @(negedge clk);
    check("rst_tx_ready", {31'd0, pe_tx_ready}, 32'd0);
    check("rst_in_ready", {31'd0, net_in_ready}, 32'd0);
    check("rst_drop", {24'd0, drop_count}, 32'd0);
    step();
    reset = 1'b0;
    step();
    @(negedge clk);
    check("post_rst_tx_ready", {31'd0, pe_tx_ready}, 32'd1);
    check("post_rst_in_ready", {31'd0, net_in_ready}, 32'd1);

    // Single packet out, no fall-through
    net_out_ready = 1'b1;
    pe_tx_valid = 1'b1; pe_tx_dest = 3'd5; pe_tx_type = 2'd1; pe_tx_data = 24'h00ABCD;
    step();
    pe_tx_valid = 1'b0;
    @(negedge clk);
    check("t1_valid", {31'd0, net_out_valid}, 32'd1);
    check("t1_data", net_out_data, 32'hA900ABCD);
    step();
    step();

    // Fill TX FIFO with output stalled, then drain in order
    net_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pe_tx_valid = 1'b1; pe_tx_dest = 3'(i); pe_tx_type = 2'd2; pe_tx_data = 24'h000100 + 24'(i);
      step();
      if (i == 3) begin
        @(negedge clk);
        check("t2_full_ready", {31'd0, pe_tx_ready}, 32'd0);
      end
    end
    pe_tx_valid = 1'b0;
    net_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t2_drain", net_out_data, {3'(k), 3'd2, 2'd2, 24'h000100 + 24'(k)});
      step();
    end
    @(negedge clk);
    check("t2_empty", {31'd0, net_out_valid}, 32'd0);

    // Addressed RX packet
    step();
    net_in_valid = 1'b1; net_in_data = 32'h4C000011;
    step();
    net_in_valid = 1'b0;
    @(negedge clk);
    check("t3_valid", {31'd0, pe_rx_valid}, 32'd1);
    check("t3_src", {29'd0, pe_rx_src}, 32'd3);
    check("t3_type", {30'd0, pe_rx_type}, 32'd0);
    check("t3_data", {8'd0, pe_rx_data}, 32'h000011);
    pe_rx_ready = 1'b1;
    step();
    pe_rx_ready = 1'b0;

    // 300 misaddressed packets with concurrent TX traffic
    for (int i = 0; i < 300; i++) begin
      net_in_valid = 1'b1; net_in_data = {3'd6, 3'd1, 2'd3, 24'(i)};
      pe_tx_valid = (i % 3 == 0); pe_tx_dest = 3'(i); pe_tx_type = 2'(i); pe_tx_data = 24'(i * 7);
      step();
    end
    net_in_valid = 1'b0; pe_tx_valid = 1'b0;
    @(negedge clk);
    check("t4_drop_sat", {24'd0, drop_count}, 32'd255);
    check("t4_rx_valid", {31'd0, pe_rx_valid}, 32'd0);
    repeat (3) step();

    // RX backpressure and recovery
    for (int i = 0; i < 6; i++) begin
      net_in_valid = 1'b1; net_in_data = {3'd2, 3'(i), 2'd1, 24'h00C000 + 24'(i)};
      step();
    end
    @(negedge clk);
    check("t5_full_ready", {31'd0, net_in_ready}, 32'd0);
    net_in_data = {3'd2, 3'd6, 2'd1, 24'h00C006};
    pe_rx_ready = 1'b1;
    step();
    pe_rx_ready = 1'b0;
    @(negedge clk);
    check("t5_ready_back", {31'd0, net_in_ready}, 32'd1);
    step();
    net_in_valid = 1'b0;
    pe_rx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t5_order_src", {29'd0, pe_rx_src}, {29'd0, srcs[k]});
      step();
    end
    @(negedge clk);
    check("t5_empty", {31'd0, pe_rx_valid}, 32'd0);
    pe_rx_ready = 1'b0;

    // Reset with buffered traffic
    net_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pe_tx_valid = 1'b1; pe_tx_dest = 3'd1; pe_tx_type = 2'd0; pe_tx_data = 24'hDEAD00 + 24'(i);
      step();
    end
    pe_tx_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      net_in_valid = 1'b1; net_in_data = {3'd2, 3'd5, 2'd2, 24'h00BEE0 + 24'(i)};
      step();
    end
    net_in_valid = 1'b0;
    net_in_data = {3'd7, 3'd0, 2'd0, 24'h0};
    net_in_valid = 1'b1;
    step();
    net_in_valid = 1'b0;
    reset = 1'b1;
    pe_tx_valid = 1'b1; net_out_ready = 1'b1; pe_rx_ready = 1'b1;
    net_in_valid = 1'b1; net_in_data = {3'd2, 3'd4, 2'd0, 24'h000777};
    step();
    @(negedge clk);
    check("t6_rst_out_valid", {31'd0, net_out_valid}, 32'd0);
    check("t6_rst_rx_valid", {31'd0, pe_rx_valid}, 32'd0);
    check("t6_rst_drop", {24'd0, drop_count}, 32'd0);
    pe_tx_valid = 1'b0; net_in_valid = 1'b0; pe_rx_ready = 1'b0;
    step();
    reset = 1'b0;
    step();
    @(negedge clk);
    check("t6_no_stale_tx", {31'd0, net_out_valid}, 32'd0);
    check("t6_no_stale_rx", {31'd0, pe_rx_valid}, 32'd0);
    check("t6_drop_clear", {24'd0, drop_count}, 32'd0);
    pe_tx_valid = 1'b1; pe_tx_dest = 3'd7; pe_tx_type = 2'd3; pe_tx_data = 24'h123456;
    net_in_valid = 1'b1; net_in_data = 32'h4ABCDEF0;
    step();
    pe_tx_valid = 1'b0; net_in_valid = 1'b0;
    @(negedge clk);
    check("t6_new_tx", net_out_data, 32'hEB123456);
    check("t6_new_rx_src", {29'd0, pe_rx_src}, 32'd2);
    check("t6_new_rx_data", {8'd0, pe_rx_data}, 32'h00BCDEF0);
    pe_rx_ready = 1'b1;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
